// File: rtl/data_mem_lsu_port_pkg.sv
// Shared encodings for the MEM-stage data memory port: access sizes, FSM states
// and the byte-enable helper.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BEAT2 = 1'b1
  } state_e;

  localparam int unsigned MAX_NB = 8;

  // Lanes above the word width spill into the upper half and become beat-2 enables.
  function automatic logic [2*MAX_NB-1:0] be_mask(input logic [3:0] off, input logic [3:0] n);
    return ((16'd1 << n) - 16'd1) << off;
  endfunction

endpackage

// File: rtl/data_mem_lsu_port_if.sv
// Request/response bundle between the MEM stage and the data memory port.
interface data_mem_lsu_port_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_sign_ext;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_sign_ext, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_sign_ext, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_lsu_port_bank.sv
// Byte-laned RAM: synchronous read, per-lane write enable, contents not reset.
module mem_byte_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  localparam int unsigned NB        = DATA_WIDTH / 8,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic [NB-1:0]         we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  for (genvar l = 0; l < NB; l++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (en_i) begin
        if (we_i[l]) mem_q[addr_i] <= wdata_i[8*l +: 8];
        rd_q <= mem_q[addr_i];
      end
    end

    assign rdata_o[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/data_mem_lsu_port.sv
// Little-endian data memory port for the MEM stage: byte/half/word/double
// accesses, sign/zero extension, misaligned accesses split over two beats or trapped.
module data_mem_lsu_port
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter bit          SPLIT_MISALIGN = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  data_mem_lsu_port_if.slave     bus
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned OFF   = $clog2(NB);
  localparam int unsigned WAW   = ADDR_WIDTH - OFF;
  localparam int unsigned DEPTH = 2 ** WAW;

  state_e                state_q, state_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_split_q, rsp_split_d;
  logic                  cap;

  logic [ADDR_WIDTH-1:0] addr_q;
  size_e                 size_q;
  logic                  sign_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] beat1_q;

  logic                  ram_en;
  logic [NB-1:0]         ram_we;
  logic [WAW-1:0]        ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Beat 2 replays the captured request; beat 1 / aligned use the live request.
  logic                    in_beat2;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  size_e                   cur_size;
  logic                    cur_we;
  logic [DATA_WIDTH-1:0]   cur_wdata;
  logic [OFF-1:0]          cur_off;
  logic [WAW-1:0]          cur_word;
  logic [3:0]              cur_n;
  logic                    illegal;
  logic                    misal;
  logic [2*NB-1:0]         be_all;
  logic [2*DATA_WIDTH-1:0] wide_wd;

  assign in_beat2  = (state_q == ST_BEAT2);
  assign cur_addr  = in_beat2 ? addr_q  : bus.req_addr;
  assign cur_size  = in_beat2 ? size_q  : size_e'(bus.req_size);
  assign cur_we    = in_beat2 ? we_q    : bus.req_we;
  assign cur_wdata = in_beat2 ? wdata_q : bus.req_wdata;
  assign cur_off   = cur_addr[OFF-1:0];
  assign cur_word  = cur_addr[ADDR_WIDTH-1:OFF];
  assign cur_n     = 4'd1 << cur_size;
  assign illegal   = (cur_size == SZ_D) && (NB != 8);
  assign misal     = (4'(cur_off) + cur_n) > 4'(NB);
  assign be_all    = (2*NB)'(be_mask(4'(cur_off), cur_n));
  assign wide_wd   = {{DATA_WIDTH{1'b0}}, cur_wdata} << {cur_off, 3'b000};

  always_comb begin
    state_d     = state_q;
    cap         = 1'b0;
    ram_en      = 1'b0;
    ram_we      = '0;
    ram_addr    = cur_word;
    ram_wdata   = wide_wd[DATA_WIDTH-1:0];
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_split_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          cap = 1'b1;
          if (illegal || (misal && !SPLIT_MISALIGN)) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            ram_en = 1'b1;
            ram_we = cur_we ? be_all[NB-1:0] : '0;
            if (misal) state_d = ST_BEAT2;
            else       rsp_valid_d = 1'b1;
          end
        end
      end
      ST_BEAT2: begin
        ram_en      = 1'b1;
        ram_addr    = cur_word + WAW'(1);
        ram_we      = cur_we ? be_all[2*NB-1:NB] : '0;
        ram_wdata   = wide_wd[2*DATA_WIDTH-1:DATA_WIDTH];
        rsp_valid_d = 1'b1;
        rsp_split_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_split_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_split_q <= rsp_split_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      addr_q  <= bus.req_addr;
      size_q  <= size_e'(bus.req_size);
      sign_q  <= bus.req_sign_ext;
      we_q    <= bus.req_we;
      wdata_q <= bus.req_wdata;
    end
    if (in_beat2) beat1_q <= ram_rdata;
  end

  mem_byte_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_bank (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // A split load lines up {word W+1, word W}, then drops the leading offset bytes.
  logic [OFF-1:0]        rsp_off;
  logic [3:0]            rsp_n;
  logic [DATA_WIDTH-1:0] rd_lo, rd_hi, assembled, extended;
  logic                  sbit;

  assign rsp_off   = addr_q[OFF-1:0];
  assign rsp_n     = 4'd1 << size_q;
  assign rd_lo     = rsp_split_q ? beat1_q : ram_rdata;
  assign rd_hi     = rsp_split_q ? ram_rdata : '0;
  assign assembled = DATA_WIDTH'({rd_hi, rd_lo} >> {rsp_off, 3'b000});

  always_comb begin
    sbit     = 1'b0;
    extended = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (4'(i + 1) == rsp_n) sbit = assembled[8*i+7];
    end
    sbit = sbit & sign_q;
    for (int unsigned i = 0; i < NB; i++) begin
      extended[8*i +: 8] = (4'(i) < rsp_n) ? assembled[8*i +: 8] : {8{sbit}};
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = (rsp_valid_q && !rsp_err_q && !we_q) ? extended : '0;

endmodule

// File: tb/tb_data_mem_lsu_port.sv
// Scoreboard bench for data_mem_lsu_port: three instances (32-bit split,
// 32-bit trapping, 64-bit split) driven one at a time with directed vectors.
module tb_data_mem_lsu_port;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          sel        = 0;
  logic        drv_valid  = 1'b0;
  logic        drv_we     = 1'b0;
  logic [1:0]  drv_size   = 2'b00;
  logic        drv_sign   = 1'b0;
  logic [9:0]  drv_addr   = '0;
  logic [63:0] drv_wdata  = '0;

  data_mem_lsu_port_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus_a ();
  data_mem_lsu_port_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus_b ();
  data_mem_lsu_port_if #(.DATA_WIDTH(64), .ADDR_WIDTH(10)) bus_c ();

  assign bus_a.req_valid    = drv_valid && (sel == 0);
  assign bus_a.req_we       = drv_we;
  assign bus_a.req_size     = drv_size;
  assign bus_a.req_sign_ext = drv_sign;
  assign bus_a.req_addr     = drv_addr;
  assign bus_a.req_wdata    = drv_wdata[31:0];

  assign bus_b.req_valid    = drv_valid && (sel == 1);
  assign bus_b.req_we       = drv_we;
  assign bus_b.req_size     = drv_size;
  assign bus_b.req_sign_ext = drv_sign;
  assign bus_b.req_addr     = drv_addr;
  assign bus_b.req_wdata    = drv_wdata[31:0];

  assign bus_c.req_valid    = drv_valid && (sel == 2);
  assign bus_c.req_we       = drv_we;
  assign bus_c.req_size     = drv_size;
  assign bus_c.req_sign_ext = drv_sign;
  assign bus_c.req_addr     = drv_addr;
  assign bus_c.req_wdata    = drv_wdata;

  data_mem_lsu_port #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .SPLIT_MISALIGN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  data_mem_lsu_port #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .SPLIT_MISALIGN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));
  data_mem_lsu_port #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .SPLIT_MISALIGN(1'b1)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c));

  typedef struct {
    int          id;
    int unsigned due;
    logic        err;
    logic [63:0] rdata;
    string       name;
  } exp_t;

  // kind: 0 req_ready, 1 rsp_valid, 2 rsp_rdata, 3 rsp_err
  typedef struct {
    int          id;
    int          kind;
    logic [63:0] val;
    string       name;
  } probe_t;

  exp_t   sb_q[$];
  probe_t pr_q[$];
  int     checks = 0;
  int     errors = 0;

  function automatic logic [63:0] obs_of(input int id, input int kind);
    case (id)
      0: case (kind)
           0: return {63'd0, bus_a.req_ready};
           1: return {63'd0, bus_a.rsp_valid};
           2: return {32'd0, bus_a.rsp_rdata};
           default: return {63'd0, bus_a.rsp_err};
         endcase
      1: case (kind)
           0: return {63'd0, bus_b.req_ready};
           1: return {63'd0, bus_b.rsp_valid};
           2: return {32'd0, bus_b.rsp_rdata};
           default: return {63'd0, bus_b.rsp_err};
         endcase
      default: case (kind)
           0: return {63'd0, bus_c.req_ready};
           1: return {63'd0, bus_c.rsp_valid};
           2: return bus_c.rsp_rdata;
           default: return {63'd0, bus_c.rsp_err};
         endcase
    endcase
  endfunction

  always @(negedge clk) begin : mon
    exp_t        e;
    probe_t      p;
    logic [63:0] o;
    for (int id = 0; id < 3; id++) begin
      if (obs_of(id, 1) == 64'd1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp dut%0d cyc=%0d: got rdata=%h err=%0d, required no response",
                   id, cyc, obs_of(id, 2), obs_of(id, 3));
        end else begin
          e = sb_q.pop_front();
          if (e.id != id || e.due != cyc || e.rdata !== obs_of(id, 2) || 64'(e.err) !== obs_of(id, 3)) begin
            errors++;
            $display("FAIL %s: got dut%0d cyc=%0d rdata=%h err=%0d, required dut%0d cyc=%0d rdata=%h err=%0d",
                     e.name, id, cyc, obs_of(id, 2), obs_of(id, 3), e.id, e.due, e.rdata, e.err);
          end
        end
      end
    end
    while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: got no response by cyc=%0d, required dut%0d cyc=%0d rdata=%h err=%0d",
               e.name, cyc, e.id, e.due, e.rdata, e.err);
    end
    while (pr_q.size() > 0) begin
      p = pr_q.pop_front();
      o = obs_of(p.id, p.kind);
      checks++;
      if (o !== p.val) begin
        errors++;
        $display("FAIL %s: got %h, required %h (dut%0d cyc=%0d)", p.name, o, p.val, p.id, cyc);
      end
    end
  end

  function automatic logic ready_of(input int id);
    return obs_of(id, 0) == 64'd1;
  endfunction

  task automatic issue(input int id, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [9:0] addr, input logic [63:0] wd, input logic exp_err,
                       input logic [63:0] exp_rd, input int unsigned lat, input string name,
                       input bit push = 1'b1);
    int n;
    @(negedge clk);
    sel       = id;
    drv_we    = we;
    drv_size  = size;
    drv_sign  = sgn;
    drv_addr  = addr;
    drv_wdata = wd;
    drv_valid = 1'b1;
    n = 0;
    while (!ready_of(id) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (push) sb_q.push_back('{id, cyc + lat, exp_err, exp_rd, name});
    @(posedge clk);
    #1 drv_valid = 1'b0;
  endtask

  task automatic probe(input int id, input int kind, input logic [63:0] val, input string name);
    pr_q.push_back('{id, kind, val, name});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    probe(0, 0, 64'd1, "reset_ready");
    probe(0, 1, 64'd0, "reset_rsp_valid");
    probe(0, 2, 64'd0, "reset_rsp_rdata");
    probe(0, 3, 64'd0, "reset_rsp_err");
    @(negedge clk);
    #1 rst = 1'b0;

    // 32-bit, split: aligned accesses and extension
    issue(0, 1, 2'b10, 0, 10'h010, 64'hDEADBEEF, 0, 64'h0, 1, "st_w_10");
    issue(0, 0, 2'b00, 1, 10'h013, 64'h0, 0, 64'hFFFFFFDE, 1, "ld_b_s_13");
    issue(0, 0, 2'b01, 0, 10'h012, 64'h0, 0, 64'h0000DEAD, 1, "ld_h_u_12");
    issue(0, 0, 2'b00, 0, 10'h010, 64'h0, 0, 64'h000000EF, 1, "ld_b_u_10");
    issue(0, 0, 2'b01, 1, 10'h010, 64'h0, 0, 64'hFFFFBEEF, 1, "ld_h_s_10");
    issue(0, 0, 2'b10, 0, 10'h010, 64'h0, 0, 64'hDEADBEEF, 1, "ld_w_10");

    // 32-bit, split: misaligned word store/load
    issue(0, 1, 2'b10, 0, 10'h00C, 64'hA5A5A5A5, 0, 64'h0, 1, "st_w_0c");
    issue(0, 1, 2'b10, 0, 10'h00E, 64'h11223344, 0, 64'h0, 2, "st_w_split_0e");
    probe(0, 0, 64'd0, "ready_low_beat2");
    issue(0, 0, 2'b10, 0, 10'h00E, 64'h0, 0, 64'h11223344, 2, "ld_w_split_0e");
    issue(0, 0, 2'b10, 0, 10'h00C, 64'h0, 0, 64'h3344A5A5, 1, "ld_w_0c");
    issue(0, 0, 2'b10, 0, 10'h010, 64'h0, 0, 64'hDEAD1122, 1, "ld_w_10_after_split");
    issue(0, 0, 2'b01, 1, 10'h00F, 64'h0, 0, 64'h00002233, 2, "ld_h_split_0f");

    // 32-bit, split: wrap from last word to word 0
    issue(0, 1, 2'b10, 0, 10'h3FE, 64'hCAFEF00D, 0, 64'h0, 2, "st_w_wrap_3fe");
    issue(0, 0, 2'b00, 0, 10'h3FE, 64'h0, 0, 64'h0000000D, 1, "ld_b_3fe");
    issue(0, 0, 2'b00, 0, 10'h3FF, 64'h0, 0, 64'h000000F0, 1, "ld_b_3ff");
    issue(0, 0, 2'b00, 0, 10'h000, 64'h0, 0, 64'h000000FE, 1, "ld_b_000");
    issue(0, 0, 2'b00, 0, 10'h001, 64'h0, 0, 64'h000000CA, 1, "ld_b_001");
    issue(0, 0, 2'b01, 1, 10'h3FF, 64'h0, 0, 64'hFFFFFEF0, 2, "ld_h_s_wrap_3ff");
    issue(0, 0, 2'b11, 0, 10'h000, 64'h0, 1, 64'h0, 1, "ld_d_illegal_32");

    // Reset during beat 2 of a split load
    issue(0, 0, 2'b10, 0, 10'h00E, 64'h0, 0, 64'h0, 2, "ld_w_aborted", 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    probe(0, 0, 64'd1, "ready_after_abort");
    probe(0, 1, 64'd0, "no_rsp_after_abort");
    issue(0, 0, 2'b10, 0, 10'h010, 64'h0, 0, 64'hDEAD1122, 1, "ld_w_after_abort");

    // 32-bit, trapping
    issue(1, 1, 2'b10, 0, 10'h000, 64'h87654321, 0, 64'h0, 1, "b_st_w_00");
    issue(1, 1, 2'b10, 0, 10'h004, 64'h0F0E0D0C, 0, 64'h0, 1, "b_st_w_04");
    issue(1, 0, 2'b01, 0, 10'h003, 64'h0, 1, 64'h0, 1, "b_ld_h_mis_03");
    issue(1, 1, 2'b01, 0, 10'h003, 64'hBEEF, 1, 64'h0, 1, "b_st_h_mis_03");
    issue(1, 0, 2'b10, 0, 10'h000, 64'h0, 0, 64'h87654321, 1, "b_ld_w_00_unchanged");
    issue(1, 0, 2'b10, 0, 10'h004, 64'h0, 0, 64'h0F0E0D0C, 1, "b_ld_w_04_unchanged");
    issue(1, 0, 2'b11, 0, 10'h000, 64'h0, 1, 64'h0, 1, "b_ld_d_illegal");
    issue(1, 0, 2'b01, 1, 10'h002, 64'h0, 0, 64'hFFFF8765, 1, "b_ld_h_s_02");

    // 64-bit, split
    issue(2, 1, 2'b11, 0, 10'h008, 64'h0123456789ABCDEF, 0, 64'h0, 1, "c_st_d_08");
    issue(2, 0, 2'b11, 0, 10'h008, 64'h0, 0, 64'h0123456789ABCDEF, 1, "c_ld_d_08");
    issue(2, 0, 2'b10, 1, 10'h00C, 64'h0, 0, 64'h0000000001234567, 1, "c_ld_w_s_0c");
    issue(2, 0, 2'b10, 1, 10'h008, 64'h0, 0, 64'hFFFFFFFF89ABCDEF, 1, "c_ld_w_s_08");
    issue(2, 0, 2'b00, 0, 10'h00F, 64'h0, 0, 64'h0000000000000001, 1, "c_ld_b_0f");
    issue(2, 1, 2'b10, 0, 10'h00E, 64'hAABBCCDD, 0, 64'h0, 2, "c_st_w_split_0e");
    issue(2, 0, 2'b01, 0, 10'h00E, 64'h0, 0, 64'h000000000000CCDD, 1, "c_ld_h_0e");
    issue(2, 0, 2'b10, 0, 10'h00E, 64'h0, 0, 64'h00000000AABBCCDD, 2, "c_ld_w_split_0e");
    issue(2, 0, 2'b11, 0, 10'h008, 64'h0, 0, 64'hCCDD456789ABCDEF, 1, "c_ld_d_08_merged");

    repeat (5) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
